maze_player_nav: RTL and testbench
==================================

// Module: maze_player_nav
// PURPOSE
//  Parametrised next-generation player movement controller for the maze game. Takes one-hot
//  direction input, bounds-checks the target cell, reads the wall bit from maze ROM with a
//  configurable read latency, and moves the player only onto free cells. Adds edge-qualified
//  moves, blocked-move flag and move counter. Sits between keypad decode and render/score logic.
// PARAMETERS
//  WIDTH        5    maze columns (1..255)
//  HEIGHT       5    maze rows (1..255)
//  ADDR_WIDTH   11   maze ROM address width; WIDTH*HEIGHT <= 2**ADDR_WIDTH
//  MEM_LATENCY  1    ROM read latency in clocks (1..4)
//  START_X/Y    0/0  start (and post-exit) cell
//  END_X/Y      WIDTH-1/HEIGHT-1  exit cell
//  REPEAT_CYCLES 8   auto-repeat period in clocks (used only with MAZE_NAV_AUTOREPEAT_EN)
// PORTS
//  clock               in   1   system clock, all logic rising-edge
//  reset               in   1   synchronous, active-high reset
//  player_direction    in   4   [0]=up [1]=down [2]=right [3]=left
//  maze_input_data     in   1   ROM wall bit: 1=wall, 0=free
//  maze_input_address  out  ADDR_WIDTH  ROM address = y*WIDTH + x
//  player_x/player_y   out  8   current cell
//  at_end              out  1   one-cycle pulse when exit cell is reached
//  blocked             out  1   one-cycle pulse: move rejected (bound or wall)
//  busy                out  1   high while a move is in FETCH/CHECK
//  move_count          out  16  completed moves since reset/exit, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset: player=(START_X,START_Y), address=START_Y*WIDTH+START_X, at_end/blocked/busy=0,
//   move_count=0, state=IDLE, armed=0. Reset mid-move aborts; no position update.
//  Press valid only if exactly one direction bit set; 0 or >1 bits = no press.
//  FSM IDLE: armed && valid press -> compute target. Out of bounds (x=0 left, y=0 up,
//   x=WIDTH-1 right, y=HEIGHT-1 down) -> blocked=1 next cycle, armed=0, stay IDLE, no ROM read.
//   Else register target address, -> FETCH (busy=1). armed set when direction==0.
//  FETCH: wait MEM_LATENCY clocks holding target address -> CHECK.
//  CHECK (1 cycle): data=1 -> blocked pulse, position kept. data=0 -> position=target,
//   move_count+1 (saturate). If target==(END_X,END_Y): position=START, move_count=0,
//   at_end=1 for that one cycle. -> IDLE, armed=0. Direction change during FETCH ignored.
//  Latency: press seen in cycle N -> position/blocked/at_end updated at edge ending N+1+MEM_LATENCY.
//  In IDLE address tracks current position; widths: address computed in ADDR_WIDTH, no wrap.
//  blocked and at_end never assert in the same cycle.
// CONFIGURATION
//  MAZE_NAV_AUTOREPEAT_EN defined: holding the same single direction re-arms every
//   REPEAT_CYCLES clocks after returning to IDLE (repeat counter cleared on release/change).
//  Undefined: strictly one move per press; direction must return to 4'b0000 to re-arm.
// STRUCTURE
//  Package maze_pkg: direction enum/one-hot constants (DIR_UP..DIR_LEFT), state enum
//   (IDLE/FETCH/CHECK), COORD_WIDTH=8, MOVE_CNT_WIDTH=16.
//  Sub-module maze_dir_decode: one-hot validity check + bounded target computation (comb).
// TESTING  (WIDTH=HEIGHT=5, MEM_LATENCY=1, macro off unless noted)
//  1 reset, dir=0001 held 8 clocks -> player (0,0), blocked one pulse, no address change.
//  2 dir=0100, data=0 -> player (1,0) after 3 clocks, move_count=1; held 8 more -> no move.
//  3 data=1, dir=0010 from (1,0) -> blocked pulse, player stays (1,0), address 6 during FETCH.
//  4 down x4, right x3 with release between, data=0 -> at_end pulse, player (0,0), count 0;
//   next cycle at_end=0.
//  5 dir=0101 -> no move, no blocked; reset asserted during FETCH -> player=(0,0), busy=0.
//  6 MAZE_NAV_AUTOREPEAT_EN, REPEAT_CYCLES=8, dir=0100 held 40 clocks -> x advances to 4.

Source files
------------

// File: rtl/maze_pkg.sv
// Shared types and constants for the maze player navigation block.
//   - one-hot direction codes carried on player_direction
//   - navigation FSM state type
//   - coordinate / move-counter widths
//   - dir_is_onehot(): single-direction press qualifier
package maze_pkg;

  localparam int unsigned COORD_WIDTH    = 8;
  localparam int unsigned MOVE_CNT_WIDTH = 16;

  typedef enum logic [3:0] {
    DIR_UP    = 4'b0001,
    DIR_DOWN  = 4'b0010,
    DIR_RIGHT = 4'b0100,
    DIR_LEFT  = 4'b1000
  } dir_e;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StCheck = 2'd2
  } nav_state_e;

  function automatic logic dir_is_onehot(input logic [3:0] dir);
    return (dir != 4'b0000) && ((dir & (dir - 4'd1)) == 4'b0000);
  endfunction

endpackage

// File: rtl/maze_dir_decode.sv
// Direction decode for maze_player_nav (purely combinational).
//   dir_i      : raw one-hot direction from the keypad
//   x_i / y_i  : current player cell
//   valid_o    : exactly one direction bit set
//   oob_o      : the requested step would leave the maze
//   tgt_x_o/y_o: neighbouring cell; equals the current cell when invalid or out of bounds
module maze_dir_decode
  import maze_pkg::*;
#(
  parameter int unsigned WIDTH  = 5,
  parameter int unsigned HEIGHT = 5
) (
  input  logic [3:0]             dir_i,
  input  logic [COORD_WIDTH-1:0] x_i,
  input  logic [COORD_WIDTH-1:0] y_i,
  output logic                   valid_o,
  output logic                   oob_o,
  output logic [COORD_WIDTH-1:0] tgt_x_o,
  output logic [COORD_WIDTH-1:0] tgt_y_o
);

  localparam logic [COORD_WIDTH-1:0] MaxX = COORD_WIDTH'(WIDTH - 1);
  localparam logic [COORD_WIDTH-1:0] MaxY = COORD_WIDTH'(HEIGHT - 1);

  always_comb begin
    valid_o = dir_is_onehot(dir_i);
    oob_o   = 1'b0;
    tgt_x_o = x_i;
    tgt_y_o = y_i;
    // Target only moves when in bounds, so the arithmetic can never wrap.
    unique case (dir_i)
      DIR_UP: begin
        oob_o = (y_i == '0);
        if (!oob_o) tgt_y_o = y_i - 1'b1;
      end
      DIR_DOWN: begin
        oob_o = (y_i >= MaxY);
        if (!oob_o) tgt_y_o = y_i + 1'b1;
      end
      DIR_RIGHT: begin
        oob_o = (x_i >= MaxX);
        if (!oob_o) tgt_x_o = x_i + 1'b1;
      end
      DIR_LEFT: begin
        oob_o = (x_i == '0);
        if (!oob_o) tgt_x_o = x_i - 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/maze_player_nav.sv
// Maze player movement controller.
// A single-direction press (after a release) is bounds-checked; in-bounds targets are
// looked up in the maze ROM (wall bit, MEM_LATENCY clocks) and the player moves only onto
// free cells. Reaching the exit cell sends the player back to the start and clears the count.
// Ports:
//   clock, reset           : rising-edge clock, synchronous active-high reset
//   player_direction [3:0] : [0]=up [1]=down [2]=right [3]=left
//   maze_input_data        : ROM wall bit (1=wall)
//   maze_input_address     : ROM address y*WIDTH+x (current cell in IDLE, target otherwise)
//   player_x / player_y    : current cell
//   at_end / blocked       : one-cycle pulses (exit reached / move rejected)
//   busy                   : move in progress (FETCH/CHECK)
//   move_count             : completed moves, saturating
// Build option: define MAZE_NAV_AUTOREPEAT_EN to re-arm a held direction every
// REPEAT_CYCLES clocks while idle.
module maze_player_nav
  import maze_pkg::*;
#(
  parameter int unsigned WIDTH         = 5,
  parameter int unsigned HEIGHT        = 5,
  parameter int unsigned ADDR_WIDTH    = 11,
  parameter int unsigned MEM_LATENCY   = 1,
  parameter int unsigned START_X       = 0,
  parameter int unsigned START_Y       = 0,
  parameter int unsigned END_X         = WIDTH - 1,
  parameter int unsigned END_Y         = HEIGHT - 1,
  parameter int unsigned REPEAT_CYCLES = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [3:0]                player_direction,
  input  logic                      maze_input_data,
  output logic [ADDR_WIDTH-1:0]     maze_input_address,
  output logic [COORD_WIDTH-1:0]    player_x,
  output logic [COORD_WIDTH-1:0]    player_y,
  output logic                      at_end,
  output logic                      blocked,
  output logic                      busy,
  output logic [MOVE_CNT_WIDTH-1:0] move_count
);

  // Elaboration-time parameter sanity checks.
  if (WIDTH < 1 || WIDTH > 255 || HEIGHT < 1 || HEIGHT > 255) begin : g_bad_dims
    $error("maze_player_nav: WIDTH/HEIGHT must be 1..255");
  end
  if (MEM_LATENCY < 1 || MEM_LATENCY > 4) begin : g_bad_lat
    $error("maze_player_nav: MEM_LATENCY must be 1..4");
  end
  if (WIDTH * HEIGHT > (1 << ADDR_WIDTH)) begin : g_bad_addr
    $error("maze_player_nav: ADDR_WIDTH too small for maze");
  end
  if (START_X >= WIDTH || END_X >= WIDTH || START_Y >= HEIGHT || END_Y >= HEIGHT)
  begin : g_bad_cells
    $error("maze_player_nav: start/end cell outside maze");
  end
  if (REPEAT_CYCLES < 1) begin : g_bad_rep
    $error("maze_player_nav: REPEAT_CYCLES must be >= 1");
  end

  localparam logic [COORD_WIDTH-1:0] StartX = COORD_WIDTH'(START_X);
  localparam logic [COORD_WIDTH-1:0] StartY = COORD_WIDTH'(START_Y);
  localparam logic [COORD_WIDTH-1:0] EndX   = COORD_WIDTH'(END_X);
  localparam logic [COORD_WIDTH-1:0] EndY   = COORD_WIDTH'(END_Y);
  localparam logic [2:0]             LatLast = 3'(MEM_LATENCY - 1);

  function automatic logic [ADDR_WIDTH-1:0] cell_addr(input logic [COORD_WIDTH-1:0] x,
                                                      input logic [COORD_WIDTH-1:0] y);
    return ADDR_WIDTH'(y) * ADDR_WIDTH'(WIDTH) + ADDR_WIDTH'(x);
  endfunction

  nav_state_e                state_q, state_d;
  logic [COORD_WIDTH-1:0]    pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [COORD_WIDTH-1:0]    tgt_x_q, tgt_x_d, tgt_y_q, tgt_y_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [2:0]                lat_cnt_q, lat_cnt_d;
  logic [MOVE_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                      armed_q, armed_d;
  logic                      blocked_q, blocked_d;
  logic                      at_end_q, at_end_d;
  logic                      busy_q, busy_d;

  logic                      dir_valid, dir_oob;
  logic [COORD_WIDTH-1:0]    dec_x, dec_y;

  maze_dir_decode #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_dir_decode (
    .dir_i   (player_direction),
    .x_i     (pos_x_q),
    .y_i     (pos_y_q),
    .valid_o (dir_valid),
    .oob_o   (dir_oob),
    .tgt_x_o (dec_x),
    .tgt_y_o (dec_y)
  );

`ifdef MAZE_NAV_AUTOREPEAT_EN
  logic [3:0]  last_dir_q, last_dir_d;
  logic [15:0] rep_cnt_q, rep_cnt_d;
`endif

  always_comb begin
    state_d   = state_q;
    pos_x_d   = pos_x_q;
    pos_y_d   = pos_y_q;
    tgt_x_d   = tgt_x_q;
    tgt_y_d   = tgt_y_q;
    lat_cnt_d = lat_cnt_q;
    cnt_d     = cnt_q;
    armed_d   = armed_q;
    blocked_d = 1'b0;
    at_end_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (player_direction == 4'b0000) armed_d = 1'b1;
        if (armed_q && dir_valid) begin
          armed_d = 1'b0;
          if (dir_oob) begin
            blocked_d = 1'b1;
          end else begin
            tgt_x_d   = dec_x;
            tgt_y_d   = dec_y;
            lat_cnt_d = '0;
            state_d   = StFetch;
          end
        end
      end
      StFetch: begin
        if (lat_cnt_q == LatLast) state_d = StCheck;
        else                      lat_cnt_d = lat_cnt_q + 3'd1;
      end
      StCheck: begin
        state_d = StIdle;
        armed_d = 1'b0;
        if (maze_input_data) begin
          blocked_d = 1'b1;
        end else if (tgt_x_q == EndX && tgt_y_q == EndY) begin
          pos_x_d  = StartX;
          pos_y_d  = StartY;
          cnt_d    = '0;
          at_end_d = 1'b1;
        end else begin
          pos_x_d = tgt_x_q;
          pos_y_d = tgt_y_q;
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

`ifdef MAZE_NAV_AUTOREPEAT_EN
    // A held single direction re-arms after REPEAT_CYCLES idle clocks.
    last_dir_d = player_direction;
    rep_cnt_d  = '0;
    if (state_q == StIdle && !armed_q && dir_valid && player_direction == last_dir_q) begin
      if (rep_cnt_q >= 16'(REPEAT_CYCLES - 1)) armed_d = 1'b1;
      else                                     rep_cnt_d = rep_cnt_q + 16'd1;
    end
`endif

    busy_d = (state_d != StIdle);
    // Address follows the player while idle and holds the target during a move.
    addr_d = busy_d ? cell_addr(tgt_x_d, tgt_y_d) : cell_addr(pos_x_d, pos_y_d);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      pos_x_q   <= StartX;
      pos_y_q   <= StartY;
      tgt_x_q   <= StartX;
      tgt_y_q   <= StartY;
      addr_q    <= cell_addr(StartX, StartY);
      lat_cnt_q <= '0;
      cnt_q     <= '0;
      armed_q   <= 1'b0;
      blocked_q <= 1'b0;
      at_end_q  <= 1'b0;
      busy_q    <= 1'b0;
`ifdef MAZE_NAV_AUTOREPEAT_EN
      last_dir_q <= '0;
      rep_cnt_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      pos_x_q   <= pos_x_d;
      pos_y_q   <= pos_y_d;
      tgt_x_q   <= tgt_x_d;
      tgt_y_q   <= tgt_y_d;
      addr_q    <= addr_d;
      lat_cnt_q <= lat_cnt_d;
      cnt_q     <= cnt_d;
      armed_q   <= armed_d;
      blocked_q <= blocked_d;
      at_end_q  <= at_end_d;
      busy_q    <= busy_d;
`ifdef MAZE_NAV_AUTOREPEAT_EN
      last_dir_q <= last_dir_d;
      rep_cnt_q  <= rep_cnt_d;
`endif
    end
  end

  assign maze_input_address = addr_q;
  assign player_x           = pos_x_q;
  assign player_y           = pos_y_q;
  assign at_end             = at_end_q;
  assign blocked            = blocked_q;
  assign busy               = busy_q;
  assign move_count         = cnt_q;

endmodule

// File: tb/tb_maze_player_nav.sv
// Bench for maze_player_nav (5x5 maze, ROM latency 1, auto-repeat off).
module tb_maze_player_nav;

  localparam int unsigned W  = 5;
  localparam int unsigned H  = 5;
  localparam int unsigned AW = 11;
  localparam int unsigned ML = 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [3:0]    player_direction = 4'b0000;
  logic          maze_input_data;
  logic [AW-1:0] maze_input_address;
  logic [7:0]    player_x, player_y;
  logic          at_end, blocked, busy;
  logic [15:0]   move_count;

  maze_player_nav #(
    .WIDTH       (W),
    .HEIGHT      (H),
    .ADDR_WIDTH  (AW),
    .MEM_LATENCY (ML)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .player_direction   (player_direction),
    .maze_input_data    (maze_input_data),
    .maze_input_address (maze_input_address),
    .player_x           (player_x),
    .player_y           (player_y),
    .at_end             (at_end),
    .blocked            (blocked),
    .busy               (busy),
    .move_count         (move_count)
  );

  always #5 clock = ~clock;

  // Behavioural ROM with one clock of read latency.
  bit   wall [0:W*H-1];
  logic rom_q = 1'b0;
  always @(posedge clock) rom_q <= wall[int'(maze_input_address) % (W*H)];
  assign maze_input_data = rom_q;

  typedef struct {
    int x;
    int y;
    int blk;
    int fin;
    int cnt;
    int lat;
  } exp_t;

  exp_t exp_q [$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   mx = 0, my = 0, mc = 0;   // game-level model of the player

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic release_dir();
    player_direction = 4'b0000;
    tick();
    tick();
  endtask

  // Press a single direction, wait for its outcome, compare, then keep holding.
  task automatic press(input logic [3:0] dir, input int hold);
    exp_t e, got_e;
    int   tx, ty, px0, py0, lat;
    bit   oob, seen, extra;
    tx = mx; ty = my;
    unique case (dir)
      4'b0001: begin oob = (my == 0);     ty = my - 1; end
      4'b0010: begin oob = (my == H - 1); ty = my + 1; end
      4'b0100: begin oob = (mx == W - 1); tx = mx + 1; end
      default: begin oob = (mx == 0);     tx = mx - 1; end
    endcase
    e = '{x: mx, y: my, blk: 0, fin: 0, cnt: mc, lat: 2 + ML};
    if (oob) begin
      e.blk = 1; e.lat = 1;
    end else if (wall[ty * W + tx]) begin
      e.blk = 1;
    end else if (tx == W - 1 && ty == H - 1) begin
      e.x = 0; e.y = 0; e.cnt = 0; e.fin = 1;
    end else begin
      e.x = tx; e.y = ty; e.cnt = (mc == 16'hFFFF) ? mc : mc + 1;
    end
    exp_q.push_back(e);
    mx = e.x; my = e.y; mc = e.cnt;

    px0 = int'(player_x); py0 = int'(player_y);
    player_direction = dir;
    lat = 0; seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      lat++;
      if (lat == 1 && !oob) begin
        check_eq("fetch_busy", busy, 1);
        check_eq("fetch_addr", maze_input_address, ty * W + tx);
      end
      if (blocked || at_end || int'(player_x) != px0 || int'(player_y) != py0) seen = 1;
    end
    if (!seen) begin
      check_eq("move_timeout", 0, 1);
      void'(exp_q.pop_front());
    end else begin
      got_e = exp_q.pop_front();
      check_eq("pos_x", player_x, got_e.x);
      check_eq("pos_y", player_y, got_e.y);
      check_eq("blocked", blocked, got_e.blk);
      check_eq("at_end", at_end, got_e.fin);
      check_eq("move_count", move_count, got_e.cnt);
      check_eq("latency", lat, got_e.lat);
      tick();
      check_eq("pulse_clear", {at_end, blocked}, 0);
      check_eq("addr_idle", maze_input_address, mx + my * W);
    end
    extra = 0;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (blocked || busy || int'(player_x) != mx || int'(player_y) != my) extra = 1;
    end
    check_eq("held_no_move", extra, 0);
    release_dir();
  endtask

  initial begin
    for (int i = 0; i < W * H; i++) wall[i] = 1'b0;
    tick(); tick(); tick();
    check_eq("rst_x", player_x, 0);
    check_eq("rst_y", player_y, 0);
    check_eq("rst_addr", maze_input_address, 0);
    check_eq("rst_flags", {at_end, blocked, busy}, 0);
    check_eq("rst_count", move_count, 0);
    reset = 1'b0;
    release_dir();

    // Up at the top edge: blocked with no ROM access; left edge likewise.
    press(4'b0001, 8);
    press(4'b1000, 2);
    // Right onto a free cell, then holding does nothing more.
    press(4'b0100, 8);
    // Wall below (1,0).
    wall[6] = 1'b1;
    press(4'b0010, 2);
    wall[6] = 1'b0;
    // Walk to the exit (4,4) from (1,0).
    for (int i = 0; i < 4; i++) press(4'b0010, 1);
    press(4'b0010, 1);            // bottom edge
    for (int i = 0; i < 3; i++) press(4'b0100, 1);

    // Two bits set: not a press.
    player_direction = 4'b0101;
    begin
      bit any;
      any = 0;
      for (int i = 0; i < 6; i++) begin
        tick();
        if (blocked || busy || player_x != 8'(mx)) any = 1;
      end
      check_eq("multi_bit_ignored", any, 0);
    end
    release_dir();

    // Reset in the middle of a move aborts it.
    press(4'b0100, 0);
    player_direction = 4'b0010;
    tick();
    check_eq("pre_reset_busy", busy, 1);
    reset = 1'b1;
    tick();
    check_eq("mid_reset_x", player_x, 0);
    check_eq("mid_reset_y", player_y, 0);
    check_eq("mid_reset_busy", busy, 0);
    check_eq("mid_reset_count", move_count, 0);
    reset = 1'b0;
    mx = 0; my = 0; mc = 0;
    release_dir();
    press(4'b0100, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
